// File: rtl/logic_op_sequencer_pkg.sv
// Shared opcode and state encodings for the logic-op sequencer and its datapath.
package logic_seq_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_NEG  = 3'b100;
    localparam logic [2:0] OP_PASS = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Opcodes 110 and 111 are unassigned.
    function automatic logic op_illegal(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/logic_op_sequencer_if.sv
// Request/response bundle between control unit and sequencer.
// LOGIC_SEQ_FLAGS_EN adds rsp_zero/rsp_neg alongside the result.
interface logic_op_sequencer_if #(parameter int DATA_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
`ifdef LOGIC_SEQ_FLAGS_EN
    logic              rsp_zero;
    logic              rsp_neg;

    modport master (output req_valid, req_op, req_a, req_b, rsp_ready,
                    input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_zero, rsp_neg);
    modport slave  (input  req_valid, req_op, req_a, req_b, rsp_ready,
                    output req_ready, rsp_valid, rsp_data, rsp_err, rsp_zero, rsp_neg);
`else
    modport master (output req_valid, req_op, req_a, req_b, rsp_ready,
                    input  req_ready, rsp_valid, rsp_data, rsp_err);
    modport slave  (input  req_valid, req_op, req_a, req_b, rsp_ready,
                    output req_ready, rsp_valid, rsp_data, rsp_err);
`endif
endinterface

// File: rtl/logic_op_sequencer_unit.sv
// Purpose: combinational logic datapath f(op,Y,B) with illegal-opcode flag.
// Latency: zero cycles. Backpressure: none, pure function of its inputs.
module logic_unit_32
    import logic_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] y,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] z,
    output logic              err
);

    // Two's complement negate as ~Y plus a rippled +1 carry.
    logic [DATA_W-1:0] carry;
    assign carry[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i < DATA_W; i++) begin : g_bit
            logic ny;
            logic bit_z;
            assign ny = ~y[i];

            if (i < DATA_W - 1) begin : g_carry
                assign carry[i+1] = ny & carry[i];
            end

            always_comb begin
                case (op)
                    OP_AND:  bit_z = y[i] & b[i];
                    OP_OR:   bit_z = y[i] | b[i];
                    OP_XOR:  bit_z = y[i] ^ b[i];
                    OP_NOT:  bit_z = ny;
                    OP_NEG:  bit_z = ny ^ carry[i];
                    OP_PASS: bit_z = b[i];
                    default: bit_z = 1'b0;
                endcase
            end
            assign z[i] = bit_z;
        end
    endgenerate

    assign err = op_illegal(op);

endmodule

// File: rtl/logic_op_sequencer.sv
// Purpose: sequences one logic op IDLE->EXEC->RESP; optional LOGIC_SEQ_FLAGS_EN flags.
// Latency: rsp_valid rises one cycle after the accept edge. Backpressure: holds RESP until rsp_ready.
module logic_op_sequencer
    import logic_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                clock,
    input  logic                clear,
    logic_op_sequencer_if.slave bus,
    output logic                busy,
    output logic [CNT_W-1:0]    op_count
);

    logic [1:0]        state;
    logic [DATA_W-1:0] y_q;
    logic [DATA_W-1:0] b_q;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] z_q;
    logic              err_q;
    logic [DATA_W-1:0] f_z;
    logic              f_err;
`ifdef LOGIC_SEQ_FLAGS_EN
    logic              zero_q;
    logic              neg_q;
`endif

    logic_unit_32 #(.DATA_W(DATA_W)) u_unit (
        .op  (op_q),
        .y   (y_q),
        .b   (b_q),
        .z   (f_z),
        .err (f_err)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state    <= ST_IDLE;
            y_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            z_q      <= '0;
            err_q    <= 1'b0;
            op_count <= '0;
`ifdef LOGIC_SEQ_FLAGS_EN
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        y_q   <= bus.req_a;
                        b_q   <= bus.req_b;
                        op_q  <= bus.req_op;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    z_q    <= f_z;
                    err_q  <= f_err;
`ifdef LOGIC_SEQ_FLAGS_EN
                    zero_q <= (f_z == '0);
                    neg_q  <= f_z[DATA_W-1];
`endif
                    state  <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        op_count <= op_count + 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_data  = z_q;
    assign bus.rsp_err   = err_q;
    assign busy          = (state != ST_IDLE);
`ifdef LOGIC_SEQ_FLAGS_EN
    assign bus.rsp_zero  = zero_q;
    assign bus.rsp_neg   = neg_q;
`endif

endmodule
